bcd_7seg_scan_driver: RTL and testbench
=======================================

Name: bcd_7seg_scan_driver

Overview:
Parametrised N-digit, time-multiplexed BCD-to-7-segment display driver. Captures a packed BCD word and scans one digit at a time onto a shared active-low segment bus with per-digit active-low anode enables. Adds leading-zero blanking, per-digit blinking, decimal points and frame-synchronous update. Sits between datapath counters and the board's common-anode display.

Parameters:
NUM_DIGITS, 4, number of digits scanned (>=1)
CLK_DIV, 50000, clock cycles each digit is held active (>=2)
BLINK_DIV, 25, full scan frames per blink half-period (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
bcd_in  in  4*NUM_DIGITS  packed BCD; digit i = bcd_in[4i+3:4i], digit 0 least significant
load  in  1  capture bcd_in and dp_in into shadow register this cycle
dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit
lz_blank_en  in  1  enable leading-zero blanking
blink_mask  in  NUM_DIGITS  1 = digit blinks
seg  out  7  {a,b,c,d,e,f,g}, active-low
dp_n  out  1  decimal point, active-low
an  out  NUM_DIGITS  anode enables, active-low, one-hot-low when active
frame_done  out  1  one-cycle pulse at end of each full scan

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: seg=7'b1111111, dp_n=1, an=all ones, frame_done=0; prescaler=0, digit index=0, blink counter=0, blink phase=0 (visible), shadow and display registers=0.
- Decode (active-low): 0->0000001, 1->1001111, 2->0010010, 3->0000110, 4->1001100, 5->0100100, 6->0100000, 7->0001111, 8->0000000, 9->0000100, 10..15->1111111.
- Capture: load=1 at a clk edge writes bcd_in/dp_in to shadow. Display register copies shadow only at frame boundary (same edge as frame_done asserts). Load mid-frame never changes the current frame (no tearing).
- Prescaler counts 0..CLK_DIV-1. At CLK_DIV-1: prescaler wraps to 0, digit index increments; NUM_DIGITS-1 wraps to 0.
- Frame boundary = the prescaler-wrap edge where index goes NUM_DIGITS-1 -> 0. On that edge: frame_done registered to 1 for exactly one cycle, display <= shadow (simultaneous load: shadow value before this edge is used; new load lands next frame), blink counter increments; when it reaches BLINK_DIV-1 it wraps to 0 and blink phase toggles.
- Outputs registered from current index/display: 1-cycle latency. Digit i is active for exactly CLK_DIV cycles per frame; frame period = NUM_DIGITS*CLK_DIV cycles.
- Digit i visible unless: (a) lz_blank_en=1 and every digit j>=i holds 0 and i!=0 (digit 0 never LZ-blanked; values 10..15 count as nonzero), or (b) blink_mask[i]=1 and blink phase=1.
- Invisible digit: an[i] held 1, seg=1111111, dp_n=1. Visible digit: an[i]=0, seg=decode, dp_n=~dp[i]. Only one an bit low at any time.
- blink_mask, lz_blank_en sampled live (not frame-buffered).
- rst asserted mid-scan: all state and outputs return to reset values immediately; scan restarts at digit 0 with prescaler 0 after release.

Test Plan:
NUM_DIGITS=4, CLK_DIV=4, BLINK_DIV=2 unless stated.
1. Assert rst -> seg=1111111, dp_n=1, an=1111, frame_done=0 without clock edge; hold after release until first edge.
2. load 0x1234, wait one frame -> an cycles 1110,1101,1011,0111 each 4 cycles with seg 1001100,0000110,0010010,1001111; frame_done pulses once every 16 cycles.
3. lz_blank_en=1, 0x0070 -> an[3],an[2] never low; digit1 seg=0001111, digit0 seg=0000001; 0x0000 -> only an[0] ever low, seg=0000001.
4. Digit value 0xA with dp_in=0001 on digit0 -> an[0]=0, seg=1111111, dp_n=0 during digit-0 slot; dp_n=1 in other slots.
5. load 0x5678 in cycle 6 of a frame showing 0x1234 -> remaining slots still show 1234 digits; 5678 appears from slot 0 of next frame.
6. blink_mask=0001 -> digit 0 lit frames 0-1, dark frames 2-3, lit 4-5; other digits unaffected; rst mid-frame restarts phase at visible.

Source files
------------

// File: rtl/bcd_7seg_scan_driver_if.sv
// Bus between a datapath and the multiplexed 7-segment scan driver.
// The master supplies BCD data and display controls; the slave drives the display pins.
interface bcd_7seg_scan_driver_if #(
    parameter int NUM_DIGITS = 4
) ();
    logic [4*NUM_DIGITS-1:0] bcd_in;
    logic                    load;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    lz_blank_en;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic [6:0]              seg;
    logic                    dp_n;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_done;

    modport master (
        output bcd_in, load, dp_in, lz_blank_en, blink_mask,
        input  seg, dp_n, an, frame_done
    );

    modport slave (
        input  bcd_in, load, dp_in, lz_blank_en, blink_mask,
        output seg, dp_n, an, frame_done
    );
endinterface

// File: rtl/bcd_7seg_scan_driver.sv
// Time-multiplexed N-digit BCD to active-low 7-segment driver for a common-anode display,
// with leading-zero blanking, per-digit blink, decimal points and frame-synchronous update.
module bcd_7seg_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 50000,
    parameter int BLINK_DIV  = 25
) (
    input logic                   clk,
    input logic                   rst,
    bcd_7seg_scan_driver_if.slave bus
);
    localparam int PW = $clog2(CLK_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST   = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [PW-1:0]         prescaler;
    logic [IW-1:0]         idx;
    logic [BW-1:0]         blink_cnt;
    logic                  blink_phase;
    logic [3:0]            shadow [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] shadow_dp;
    logic [3:0]            disp [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] disp_dp;

    logic                  slot_end;
    logic                  frame_end;
    logic                  visible;
    logic                  all_zero;
    logic [NUM_DIGITS-1:0] lz_mask;
    logic [3:0]            cur_digit;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign slot_end  = (prescaler == PRE_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);
    assign cur_digit = disp[idx];

    // lz_mask[i] is set when digit i and everything above it is zero; digit 0 is never blanked.
    always_comb begin
        all_zero = 1'b1;
        lz_mask  = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            all_zero   = all_zero && (disp[i] == 4'd0);
            lz_mask[i] = all_zero;
        end
    end

    assign visible = !(bus.lz_blank_en && lz_mask[idx]) && !(bus.blink_mask[idx] && blink_phase);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler      <= '0;
            idx            <= '0;
            blink_cnt      <= '0;
            blink_phase    <= 1'b0;
            shadow_dp      <= '0;
            disp_dp        <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow[i] <= 4'd0;
                disp[i]   <= 4'd0;
            end
            bus.seg        <= 7'b1111111;
            bus.dp_n       <= 1'b1;
            bus.an         <= '1;
            bus.frame_done <= 1'b0;
        end else begin
            if (bus.load) begin
                shadow_dp <= bus.dp_in;
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    shadow[i] <= bus.bcd_in[4*i +: 4];
                end
            end

            if (slot_end) begin
                prescaler <= '0;
                idx       <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                prescaler <= prescaler + 1'b1;
            end

            // Display only follows the shadow at a frame boundary, so a frame never tears.
            if (frame_end) begin
                disp_dp <= shadow_dp;
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    disp[i] <= shadow[i];
                end
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end

            bus.frame_done <= frame_end;
            bus.an         <= '1;
            if (visible) begin
                bus.an[idx] <= 1'b0;
                bus.seg     <= decode(cur_digit);
                bus.dp_n    <= ~disp_dp[idx];
            end else begin
                bus.seg     <= 7'b1111111;
                bus.dp_n    <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bcd_7seg_scan_driver.sv
// Directed bench for the scan driver: 4 digits, 4 cycles per digit, blink every 2 frames.
module tb_bcd_7seg_scan_driver;
    localparam int ND = 4;
    localparam int CD = 4;
    localparam int BD = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    logic [3:0] an_s  [128];
    logic [6:0] seg_s [128];
    logic       dp_s  [128];
    logic       fd_s  [128];

    bcd_7seg_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

    bcd_7seg_scan_driver #(
        .NUM_DIGITS(ND),
        .CLK_DIV   (CD),
        .BLINK_DIV (BD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] dec(input logic [3:0] v);
        case (v)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001111;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic capture(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            an_s[c]  = bus.an;
            seg_s[c] = bus.seg;
            dp_s[c]  = bus.dp_n;
            fd_s[c]  = bus.frame_done;
        end
    endtask

    task automatic wait_frame();
        int k;
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (bus.frame_done !== 1'b1 && k < 100);
        if (bus.frame_done !== 1'b1) begin
            tests++; fails++;
            $display("FAIL wait_frame: frame_done=%b after %0d cycles, required 1", bus.frame_done, k);
        end
    endtask

    task automatic do_load(input logic [15:0] w, input logic [3:0] dp);
        bus.bcd_in = w;
        bus.dp_in  = dp;
        bus.load   = 1'b1;
        @(posedge clk); #1;
        bus.load   = 1'b0;
    endtask

    task automatic test_reset();
        #3 rst = 1'b1;
        #1;
        tests++;
        if ({bus.seg, bus.dp_n, bus.an, bus.frame_done} !== {7'b1111111, 1'b1, 4'b1111, 1'b0}) begin
            fails++;
            $display("FAIL reset_async: seg=%b dp_n=%b an=%b fd=%b, required 1111111 1 1111 0",
                     bus.seg, bus.dp_n, bus.an, bus.frame_done);
        end
        #13 rst = 1'b0;
        #2;
        tests++;
        if ({bus.seg, bus.dp_n, bus.an, bus.frame_done} !== {7'b1111111, 1'b1, 4'b1111, 1'b0}) begin
            fails++;
            $display("FAIL reset_hold: seg=%b dp_n=%b an=%b fd=%b, required 1111111 1 1111 0",
                     bus.seg, bus.dp_n, bus.an, bus.frame_done);
        end
        @(posedge clk); #1;
        tests++;
        if ({bus.seg, bus.dp_n, bus.an, bus.frame_done} !== {7'b0000001, 1'b1, 4'b1110, 1'b0}) begin
            fails++;
            $display("FAIL reset_first_edge: seg=%b dp_n=%b an=%b fd=%b, required 0000001 1 1110 0",
                     bus.seg, bus.dp_n, bus.an, bus.frame_done);
        end
    endtask

    task automatic test_scan();
        logic [15:0] w;
        int k;
        w = 16'h1234;
        do_load(w, 4'b0000);
        wait_frame();
        wait_frame();
        capture(16);
        for (int c = 0; c < 16; c++) begin
            k = c / CD;
            tests++;
            if (an_s[c] !== ~(4'b0001 << k) || seg_s[c] !== dec(w[4*k +: 4]) || dp_s[c] !== 1'b1) begin
                fails++;
                $display("FAIL scan c=%0d: an=%b seg=%b dp_n=%b, required an=%b seg=%b dp_n=1",
                         c, an_s[c], seg_s[c], dp_s[c], ~(4'b0001 << k), dec(w[4*k +: 4]));
            end
            tests++;
            if (fd_s[c] !== (c == 15)) begin
                fails++;
                $display("FAIL scan_frame_done c=%0d: fd=%b, required %b", c, fd_s[c], (c == 15));
            end
        end
    endtask

    task automatic test_lz();
        logic [15:0] w [2];
        logic [3:0]  vis [2];
        logic [3:0]  ea;
        logic [6:0]  es;
        int k;
        w[0] = 16'h0070; vis[0] = 4'b0011;
        w[1] = 16'h0000; vis[1] = 4'b0001;
        bus.lz_blank_en = 1'b1;
        for (int t = 0; t < 2; t++) begin
            do_load(w[t], 4'b0000);
            wait_frame();
            wait_frame();
            capture(16);
            for (int c = 0; c < 16; c++) begin
                k  = c / CD;
                ea = vis[t][k] ? ~(4'b0001 << k) : 4'b1111;
                es = vis[t][k] ? dec(w[t][4*k +: 4]) : 7'b1111111;
                tests++;
                if (an_s[c] !== ea || seg_s[c] !== es) begin
                    fails++;
                    $display("FAIL lz w=%h c=%0d: an=%b seg=%b, required an=%b seg=%b",
                             w[t], c, an_s[c], seg_s[c], ea, es);
                end
            end
        end
        bus.lz_blank_en = 1'b0;
    endtask

    task automatic test_dp_invalid();
        logic [6:0] es;
        int k;
        do_load(16'h000A, 4'b0001);
        wait_frame();
        wait_frame();
        capture(16);
        for (int c = 0; c < 16; c++) begin
            k  = c / CD;
            es = (k == 0) ? 7'b1111111 : 7'b0000001;
            tests++;
            if (an_s[c] !== ~(4'b0001 << k) || seg_s[c] !== es || dp_s[c] !== (k != 0)) begin
                fails++;
                $display("FAIL dp_invalid c=%0d: an=%b seg=%b dp_n=%b, required an=%b seg=%b dp_n=%b",
                         c, an_s[c], seg_s[c], dp_s[c], ~(4'b0001 << k), es, (k != 0));
            end
        end
    endtask

    task automatic test_no_tear();
        logic [15:0] w_old;
        logic [15:0] w_new;
        int k;
        w_old = 16'h1234;
        w_new = 16'h5678;
        do_load(w_old, 4'b0000);
        wait_frame();
        wait_frame();
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            an_s[c]  = bus.an;
            seg_s[c] = bus.seg;
            if (c == 5) begin
                bus.bcd_in = w_new;
                bus.load   = 1'b1;
            end
            if (c == 6) bus.load = 1'b0;
        end
        for (int c = 0; c < 16; c++) begin
            k = c / CD;
            tests++;
            if (an_s[c] !== ~(4'b0001 << k) || seg_s[c] !== dec(w_old[4*k +: 4])) begin
                fails++;
                $display("FAIL no_tear_old c=%0d: an=%b seg=%b, required an=%b seg=%b",
                         c, an_s[c], seg_s[c], ~(4'b0001 << k), dec(w_old[4*k +: 4]));
            end
        end
        capture(16);
        for (int c = 0; c < 16; c++) begin
            k = c / CD;
            tests++;
            if (an_s[c] !== ~(4'b0001 << k) || seg_s[c] !== dec(w_new[4*k +: 4])) begin
                fails++;
                $display("FAIL no_tear_new c=%0d: an=%b seg=%b, required an=%b seg=%b",
                         c, an_s[c], seg_s[c], ~(4'b0001 << k), dec(w_new[4*k +: 4]));
            end
        end
    endtask

    task automatic test_blink();
        logic [3:0] ea;
        logic [6:0] es;
        logic       lit;
        int f, k;
        rst = 1'b1;
        #2 rst = 1'b0;
        bus.blink_mask = 4'b0001;
        bus.bcd_in     = 16'h1234;
        bus.dp_in      = 4'b0000;
        bus.load       = 1'b1;
        for (int c = 0; c < 102; c++) begin
            @(posedge clk); #1;
            an_s[c]  = bus.an;
            seg_s[c] = bus.seg;
            if (c == 0) bus.load = 1'b0;
        end
        for (int c = 0; c < 102; c++) begin
            f   = c / 16;
            k   = (c % 16) / CD;
            lit = !(f == 2 || f == 3 || f == 6);
            ea  = (k != 0 || lit) ? ~(4'b0001 << k) : 4'b1111;
            tests++;
            if (an_s[c] !== ea) begin
                fails++;
                $display("FAIL blink_an f=%0d c=%0d: an=%b, required %b", f, c, an_s[c], ea);
            end
            if (k == 0) begin
                es = !lit ? 7'b1111111 : (f == 0) ? 7'b0000001 : 7'b1001100;
                tests++;
                if (seg_s[c] !== es) begin
                    fails++;
                    $display("FAIL blink_seg f=%0d c=%0d: seg=%b, required %b", f, c, seg_s[c], es);
                end
            end
        end
        #1 rst = 1'b1;
        #1;
        tests++;
        if ({bus.seg, bus.dp_n, bus.an, bus.frame_done} !== {7'b1111111, 1'b1, 4'b1111, 1'b0}) begin
            fails++;
            $display("FAIL midscan_reset: seg=%b dp_n=%b an=%b fd=%b, required 1111111 1 1111 0",
                     bus.seg, bus.dp_n, bus.an, bus.frame_done);
        end
        @(posedge clk); #2;
        rst = 1'b0;
        capture(16);
        tests++;
        if (an_s[0] !== 4'b1110 || seg_s[0] !== 7'b0000001 || dp_s[0] !== 1'b1) begin
            fails++;
            $display("FAIL restart_visible: an=%b seg=%b dp_n=%b, required an=1110 seg=0000001 dp_n=1",
                     an_s[0], seg_s[0], dp_s[0]);
        end
        tests++;
        if (an_s[4] !== 4'b1101) begin
            fails++;
            $display("FAIL restart_slot1: an=%b, required 1101", an_s[4]);
        end
        for (int c = 0; c < 16; c++) begin
            tests++;
            if (fd_s[c] !== (c == 15)) begin
                fails++;
                $display("FAIL restart_frame_done c=%0d: fd=%b, required %b", c, fd_s[c], (c == 15));
            end
        end
        bus.blink_mask = 4'b0000;
    endtask

    initial begin
        bus.bcd_in      = '0;
        bus.load        = 1'b0;
        bus.dp_in       = '0;
        bus.lz_blank_en = 1'b0;
        bus.blink_mask  = '0;
        test_reset();
        test_scan();
        test_lz();
        test_dp_invalid();
        test_no_tear();
        test_blink();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
